// File: rtl/prbs_byte_scheduler_if.sv
// Handshake and control bundle between the burst controller, the PRBS byte
// scheduler and the UART TX byte input.
interface prbs_byte_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] burst_len;
  logic             seed_load;
  logic [7:0]       seed;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bytes_sent;

  modport master (
    output start, abort, burst_len, seed_load, seed, tx_ready,
    input  tx_data, tx_valid, busy, done, bytes_sent
  );

  modport slave (
    input  start, abort, burst_len, seed_load, seed, tx_ready,
    output tx_data, tx_valid, busy, done, bytes_sent
  );
endinterface

// File: rtl/prbs_byte_scheduler.sv
// Feeds bursts of PRBS bytes to the UART TX over valid/ready, with optional idle
// gaps between accepted bytes, an accepted-byte counter and a burst-done pulse.
module prbs_byte_scheduler #(
  parameter int         CNT_W      = 16,
  parameter int         GAP_CYCLES = 16,
  parameter logic [7:0] SEED       = 8'hFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_srst,
  prbs_byte_scheduler_if.slave  bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // The gap counter is loaded with GAP_CYCLES-1 and the GAP state exits on zero.
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [7:0] prbs_step(input logic [7:0] p);
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
  endfunction

  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? 8'hFF : s;
  endfunction

  state_t           r_state;
  logic [7:0]       r_prbs;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_bytes_sent;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_tx_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_hs;
  logic [CNT_W-1:0] w_sent_inc;

  assign w_hs       = r_tx_valid & bus.tx_ready;
  assign w_sent_inc = r_bytes_sent + CNT_W'(1);

  // Burst sequencer: state, PRBS register, counters and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_prbs       <= SEED;
      r_len        <= '0;
      r_bytes_sent <= '0;
      r_gap_cnt    <= '0;
      r_tx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else if (i_srst) begin
      r_state      <= ST_IDLE;
      r_prbs       <= SEED;
      r_len        <= '0;
      r_bytes_sent <= '0;
      r_gap_cnt    <= '0;
      r_tx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          if (bus.start) begin
            r_bytes_sent <= '0;
            if (bus.burst_len != '0) begin
              r_len      <= bus.burst_len;
              r_state    <= ST_SEND;
              r_tx_valid <= 1'b1;
              r_busy     <= 1'b1;
              if (bus.seed_load) begin
                r_prbs <= seed_fix(bus.seed);
              end else begin
                r_prbs <= r_prbs;
              end
            end else begin
              // Empty burst: report completion without ever offering a byte.
              r_done <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_SEND: begin
          if (w_hs) begin
            r_prbs       <= prbs_step(r_prbs);
            r_bytes_sent <= w_sent_inc;
          end else begin
            r_prbs <= r_prbs;
          end
          if (bus.abort) begin
            r_state    <= ST_IDLE;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_hs) begin
            if (w_sent_inc == r_len) begin
              r_state    <= ST_DONE;
              r_tx_valid <= 1'b0;
              r_done     <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              r_state    <= ST_SEND;
              r_tx_valid <= 1'b1;
            end else begin
              r_state    <= ST_GAP;
              r_tx_valid <= 1'b0;
              r_gap_cnt  <= GAP_LOAD;
            end
          end else begin
            r_state <= ST_SEND;
          end
        end

        ST_GAP: begin
          if (bus.abort) begin
            r_state    <= ST_IDLE;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
          end else if (r_gap_cnt == '0) begin
            r_state    <= ST_SEND;
            r_tx_valid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end

        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end

        default: begin
          r_state    <= ST_IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_data    = r_prbs;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.bytes_sent = r_bytes_sent;

endmodule
